// File: rtl/sd_to_binary_converter_pkg.sv
// ---------------------------------------------------------------------------
// sd_conv_pkg
//
// Shared definitions for the signed-digit to binary converter:
//   - conv_state_e : controller states (IDLE, CONV, DONE)
//   - SD_*         : (pos,neg) bit-pair encodings of one signed digit
//   - calc_nchunk  : number of CHUNK-wide slices in a WIDTH-digit word
// ---------------------------------------------------------------------------
package sd_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    // Digit encodings as {pos, neg}. Both 00 and 11 mean zero; 11 is
    // legal and arrives naturally from the redundant adders.
    localparam logic [1:0] SD_ZERO     = 2'b00;
    localparam logic [1:0] SD_POS      = 2'b10;
    localparam logic [1:0] SD_NEG      = 2'b01;
    localparam logic [1:0] SD_ZERO_ALT = 2'b11;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/sd_to_binary_converter_if.sv
// ---------------------------------------------------------------------------
// sd_to_binary_converter_if
//
// Handshake bundle for the converter.
//   in_valid/in_ready/in_pos/in_neg : SD word in (producer -> converter)
//   out_valid/out_ready/out_bin     : binary result out (converter -> consumer)
//   out_zero                        : result-is-zero flag, only when
//                                     SD2B_ZERO_FLAG_EN is defined
// Modports: master = producer/consumer side, slave = converter side.
// ---------------------------------------------------------------------------
interface sd_to_binary_converter_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pos;
    logic [WIDTH-1:0] in_neg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_bin;
`ifdef SD2B_ZERO_FLAG_EN
    logic             out_zero;

    modport master (
        output in_valid, in_pos, in_neg, out_ready,
        input  in_ready, out_valid, out_bin, out_zero
    );

    modport slave (
        input  in_valid, in_pos, in_neg, out_ready,
        output in_ready, out_valid, out_bin, out_zero
    );
`else
    modport master (
        output in_valid, in_pos, in_neg, out_ready,
        input  in_ready, out_valid, out_bin
    );

    modport slave (
        input  in_valid, in_pos, in_neg, out_ready,
        output in_ready, out_valid, out_bin
    );
`endif

endinterface

// File: rtl/sd_to_binary_converter_chunk_sub.sv
// ---------------------------------------------------------------------------
// sd_chunk_sub
//
// Combinational CHUNK-wide slice of pos - neg, done as pos + ~neg + cin.
//   pos  [CHUNK] : positive digit bits of this slice
//   neg  [CHUNK] : negative digit bits of this slice
//   cin          : carry in (1 for the least significant slice)
//   diff [CHUNK] : slice result bits
//   cout         : carry out to the next slice
// ---------------------------------------------------------------------------
module sd_chunk_sub #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] pos,
    input  logic [CHUNK-1:0] neg,
    input  logic             cin,
    output logic [CHUNK-1:0] diff,
    output logic             cout
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    // Plain ripple: CHUNK is small, so the chain stays short.
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            logic nb;
            logic p;
            assign nb            = ~neg[gi];
            assign p             = pos[gi] ^ nb;
            assign diff[gi]      = p ^ carry[gi];
            assign carry[gi + 1] = (pos[gi] & nb) | (p & carry[gi]);
        end
    endgenerate

    assign cout = carry[CHUNK];

endmodule

// File: rtl/sd_to_binary_converter.sv
// ---------------------------------------------------------------------------
// sd_to_binary_converter
//
// Turns one signed-digit word (in_pos - in_neg) into a WIDTH+1 bit
// two's-complement value, converting CHUNK digits per cycle so the carry
// path is CHUNK long regardless of WIDTH.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sd_to_binary_converter_if.slave (input and output handshakes)
//
// Optional feature: define SD2B_ZERO_FLAG_EN to add the registered
// out_zero flag (set when the finished result is zero).
//
// Flow: IDLE accepts a word, CONV runs NCHUNK cycles (one slice each),
// DONE presents the result until the consumer takes it.
// ---------------------------------------------------------------------------
module sd_to_binary_converter
    import sd_conv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    sd_to_binary_converter_if.slave   bus
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("sd_to_binary_converter: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    conv_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] neg_q, neg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   out_bin_q, out_bin_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SD2B_ZERO_FLAG_EN
    logic             out_zero_q, out_zero_d;
`endif

    logic [CHUNK-1:0]       chunk_diff;
    logic                   chunk_cout;
    logic [WIDTH+CHUNK-1:0] acc_ext;
    logic [WIDTH-1:0]       acc_shifted;
    logic [WIDTH:0]         final_bin;

    // The operand registers shift right one slice per CONV cycle, so the
    // subtractor always sees the low CHUNK bits and needs no index mux.
    sd_chunk_sub #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .pos  (pos_q[CHUNK-1:0]),
        .neg  (neg_q[CHUNK-1:0]),
        .cin  (carry_q),
        .diff (chunk_diff),
        .cout (chunk_cout)
    );

    // Results enter the accumulator from the top; after NCHUNK slices the
    // first slice has reached bit 0 and the word is in natural order.
    assign acc_ext     = {chunk_diff, acc_q};
    assign acc_shifted = WIDTH'(acc_ext >> CHUNK);
    // Sign: no final carry-out means pos < neg.
    assign final_bin   = {~chunk_cout, acc_shifted};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        pos_d     = pos_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        out_bin_d = out_bin_q;
`ifdef SD2B_ZERO_FLAG_EN
        out_zero_d = out_zero_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    pos_d   = bus.in_pos;
                    neg_d   = bus.in_neg;
                    carry_d = 1'b1;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                pos_d   = pos_q >> CHUNK;
                neg_d   = neg_q >> CHUNK;
                carry_d = chunk_cout;
                acc_d   = acc_shifted;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    // Output register only changes here, so out_bin holds
                    // through DONE and while the next word is converting.
                    out_bin_d = final_bin;
`ifdef SD2B_ZERO_FLAG_EN
                    out_zero_d = (final_bin == '0);
`endif
                    idx_d     = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state, so
        // neither depends combinationally on in_valid or out_ready.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b1;
            pos_q       <= '0;
            neg_q       <= '0;
            acc_q       <= '0;
            out_bin_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SD2B_ZERO_FLAG_EN
            out_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            out_bin_q   <= out_bin_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SD2B_ZERO_FLAG_EN
            out_zero_q  <= out_zero_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = out_bin_q;
`ifdef SD2B_ZERO_FLAG_EN
    assign bus.out_zero  = out_zero_q;
`endif

endmodule

// File: tb/tb_sd_to_binary_converter.sv
// ---------------------------------------------------------------------------
// tb_sd_to_binary_converter
//
// Directed vectors with hand-computed results for the default
// WIDTH=16 / CHUNK=4 converter. Define SD2B_ZERO_FLAG_EN to also check
// the out_zero flag.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_to_binary_converter;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int BOUND = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vec_cnt = 0;
    int miscompare_cnt = 0;

    sd_to_binary_converter_if #(.WIDTH(WIDTH)) bus ();

    sd_to_binary_converter #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_result(input string tag, input logic [31:0] got,
                                input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one word and complete the input handshake; returns at the
    // negedge after the accepting edge.
    task automatic put_word(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n);
        int waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        check_result("in_ready_before_put", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_pos   = p;
        bus.in_neg   = n;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid, check latency and value, leave result pending.
    task automatic wait_result(input string tag, input logic [WIDTH:0] exp);
        int lat = 0;
        while (!bus.out_valid && lat < BOUND) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_result({tag, "_latency"}, 32'(lat), 32'(NCHUNK));
        check_result({tag, "_out_bin"}, 32'(bus.out_bin), 32'(exp));
        $display("word %s: out_bin=%h expected=%h latency=%0d", tag, bus.out_bin, exp, lat);
    endtask

    task automatic pop_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_result({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check_result({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_word(input string tag, input logic [WIDTH-1:0] p,
                            input logic [WIDTH-1:0] n, input logic [WIDTH:0] exp);
        put_word(p, n);
        wait_result(tag, exp);
        pop_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH:0] held;

        bus.in_valid  = 1'b0;
        bus.in_pos    = '0;
        bus.in_neg    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_result("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_result("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_result("rst_out_bin", 32'(bus.out_bin), 32'd0);
`ifdef SD2B_ZERO_FLAG_EN
        check_result("rst_out_zero", 32'(bus.out_zero), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_result("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed vectors
        run_word("pos5",    16'h0005, 16'h0000, 17'h00005);
        run_word("neg1",    16'h0000, 16'h0001, 17'h1FFFF);
        run_word("maxpos",  16'hFFFF, 16'h0000, 17'h0FFFF);
        run_word("maxneg",  16'h0000, 16'hFFFF, 17'h10001);
        run_word("carry",   16'h8000, 16'h7FFF, 17'h00001);

        put_word(16'hA5A5, 16'hA5A5);
        wait_result("zero11", 17'h00000);
`ifdef SD2B_ZERO_FLAG_EN
        check_result("zero11_flag", 32'(bus.out_zero), 32'd1);
`endif
        pop_result("zero11");

        put_word(16'h0001, 16'h0000);
        wait_result("one", 17'h00001);
`ifdef SD2B_ZERO_FLAG_EN
        check_result("one_flag", 32'(bus.out_zero), 32'd0);
`endif
        pop_result("one");

        // Backpressure: 0x00FF - 0x0F00 = -0xE01 -> 0x1F1FF
        put_word(16'h00FF, 16'h0F00);
        wait_result("bp", 17'h1F1FF);
        held = bus.out_bin;
        bus.in_valid = 1'b1;
        bus.in_pos   = 16'h0007;
        bus.in_neg   = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_result("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            check_result("bp_bin_hold", 32'(bus.out_bin), 32'(held));
            check_result("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        pop_result("bp");
        // A word latched during DONE would surface here as a new result.
        repeat (NCHUNK + 2) @(posedge clk);
        @(negedge clk);
        check_result("bp_no_latch", 32'(bus.out_valid), 32'd0);
        check_result("bp_bin_kept", 32'(bus.out_bin), 32'h1F1FF);

        // Mid-conversion reset during the second CONV cycle
        put_word(16'hFFFF, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_result("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_result("mrst_out_bin", 32'(bus.out_bin), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_result("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_result("mrst_no_output", 32'(bus.out_valid), 32'd0);
        run_word("after_rst", 16'h1234, 16'h0034, 17'h01200);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule

// File: doc/sd_to_binary_converter.md
# sd_to_binary_converter

- Converts one redundant signed-digit (SD) word, a positive/negative digit-vector pair, into a two's-complement binary word.
- It is the back end of the hybrid radix-2 adder datapath. The adders produce SD results, and this block turns them into plain binary for downstream logic.
- The conversion is carry-propagating and runs digit-serially, CHUNK digits per cycle. This bounds the critical path independently of WIDTH.
- Input and output each use a valid/ready handshake.

## Interface

Parameters:
- WIDTH, default 16: number of SD digits per word. Must be a multiple of CHUNK.
- CHUNK, default 4: digits converted per cycle. NCHUNK = WIDTH/CHUNK.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block can accept a word
- in_pos  input  WIDTH  positive digit bits; digit i = in_pos[i] - in_neg[i]
- in_neg  input  WIDTH  negative digit bits
- out_valid  output  1  out_bin holds a result
- out_ready  input  1  consumer accepts the result
- out_bin  output  WIDTH+1  two's-complement value of the input, range ±(2^WIDTH-1)
- out_zero  output  1  result equals zero (present only with SD2B_ZERO_FLAG_EN)

## Operation

Digit encoding per position (pos,neg):
- 00 = 0
- 10 = +1
- 01 = -1
- 11 = 0 (accepted; no error)

Arithmetic:
- out_bin = {1'b0,in_pos} - {1'b0,in_neg}, computed as pos + ~neg + 1.
- The carry register initialises to 1.
- Chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) computes sum = pos_k + ~neg_k + carry. The sum goes into result bits [k*CHUNK +: CHUNK]; carry takes the chunk's carry-out.
- After the last chunk, out_bin[WIDTH] = ~carry.

State machine (IDLE, CONV, DONE):
- IDLE: in_ready = 1. On in_valid & in_ready, latch in_pos/in_neg, set carry = 1 and idx = 0, go to CONV.
- CONV: process chunk idx each cycle and increment idx. When idx == NCHUNK-1, write the sign bit and go to DONE.
- CONV and DONE ignore in_valid; in_ready = 0.
- DONE: out_valid = 1. On out_ready, go to IDLE.
- DONE → CONV cannot occur directly; a new word is accepted only in IDLE.

Output holding and reset:
- out_bin (and out_zero) are registered. They stay stable from the rise of out_valid until the output handshake, and hold their last value after it.
- Reset while rst is high, at any state including mid-CONV: state → IDLE, idx = 0, carry = 1, result = 0. The in-flight word is discarded with no partial output.

## Timing

Reset values:
- out_valid = 0
- out_bin = 0
- out_zero = 0
- in_ready = 0 while rst is high; 1 in the first cycle after rst deasserts.

Latency and throughput:
- Latency: input handshake at edge E0; out_valid rises after edge E0+NCHUNK (4 cycles at defaults).
- Minimum throughput: one word per NCHUNK+2 cycles (CONV×NCHUNK, DONE, IDLE).
- out_valid & out_ready in DONE → IDLE next cycle, and out_valid drops there.

Handshake rules:
- in_ready and out_valid are driven only from state; no combinational path from in_valid or out_ready.
- Backpressure: out_valid stays high for as long as out_ready is low; no timeout.

## Configuration

- Macro SD2B_ZERO_FLAG_EN.
- Defined: the out_zero port exists. It is registered and set when the DONE result is all-zero, with the same timing as out_bin. It is cleared by reset.
- Undefined: the out_zero port and its logic are absent; all other behaviour is identical.

## Structure

- Package sd_conv_pkg holds:
  - state enum (IDLE, CONV, DONE)
  - SD digit encoding constants (SD_ZERO, SD_POS, SD_NEG, SD_ZERO_ALT)
  - a function computing NCHUNK.
- Sub-module sd_chunk_sub: a combinational CHUNK-wide subtractor with inputs pos, neg, cin and outputs diff, cout. It is instantiated once.
- The top level holds the FSM, idx counter, carry register, operand latches and result register.
- A parameter check fails elaboration when WIDTH % CHUNK != 0.

## Test plan

Defaults WIDTH=16, CHUNK=4 throughout.
- Simple positive: pos=16'h0005, neg=16'h0000 → out_bin=17'h00005 four cycles after the handshake.
- Negative one: pos=16'h0000, neg=16'h0001 → out_bin=17'h1FFFF (-1).
- Extremes:
  - pos=16'hFFFF, neg=0 → 17'h0FFFF.
  - pos=0, neg=16'hFFFF → 17'h10001.
  - pos=16'h8000, neg=16'h7FFF → 17'h00001 (full carry chain).
- Zero via the 11 encoding: pos=neg=16'hA5A5 → out_bin=0. With the macro defined, out_zero=1; a following word 16'h0001/0 gives out_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data. Required: out_valid stays 1, out_bin is unchanged, in_ready=0, and the new word is not latched.
- Mid-conversion reset: rst pulsed for one cycle during the 2nd CONV cycle. Required next cycle: out_valid=0, out_bin=0, in_ready=1. The next word, 16'h1234/16'h0034, then yields 17'h01200.
